// File: rtl/alu_issue_ctrl_if.sv
// Decode-side and writeback-side valid/ready bundle for alu_issue_ctrl.
// The controller takes the slave view; the decode/writeback side takes master.
interface alu_issue_ctrl_if #(
  parameter int DW = 16
) ();
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer in front of the combinational EX ALU; owns FLAGS {Z,V,N}.
// Optional macro ALU_RED_MULTICYCLE_EN: RED spends a second cycle (EXEC2) before capture.
module alu_issue_ctrl #(
  parameter int DW   = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus,
  input  logic            flush,
  output logic [3:0]      alu_opcode,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_n,
  output logic [2:0]      flags,
  output logic [CNTW-1:0] op_count
);

`ifdef ALU_RED_MULTICYCLE_EN
  localparam bit RED_MULTI = 1'b1;
`else
  localparam bit RED_MULTI = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_RED = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  typedef enum logic [1:0] {IDLE, EXEC, EXEC2, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q;
  logic [DW-1:0]   a_q, b_q, result_q;
  logic [2:0]      flags_q, flags_d;
  logic [CNTW-1:0] count_q;
  logic            accept, capture, retire;

  // NOTE: every comb output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
        EXEC: if (RED_MULTI && op_q == OP_RED) begin
          state_d = EXEC2;
        end else begin
          capture = 1'b1;
          state_d = DONE;
        end
        EXEC2: begin
          capture = 1'b1;
          state_d = DONE;
        end
        DONE: if (bus.out_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-opcode flag update; memory-class ops (opcode[3]) and RED/PADDSB keep FLAGS.
  always_comb begin
    flags_d = flags_q;
    unique case (op_q)
      OP_ADD, OP_SUB:                 flags_d = {alu_z, alu_v, alu_n};
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[2] = alu_z;
      default:                        flags_d = flags_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; operand latches are
  // reset too because they drive the alu_* outputs straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.in_opcode;
        a_q  <= bus.in_a;
        b_q  <= bus.in_b;
      end
      if (capture) begin
        result_q <= alu_out;
        flags_q  <= flags_d;
      end
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  // Address-generation ops reuse the adder while executing.
  assign alu_opcode = ((state_q == EXEC || state_q == EXEC2) && op_q[3]) ? OP_ADD : op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign flags          = flags_q;
  assign op_count       = count_q;

endmodule
